// File: rtl/l2_port_pkg.sv
// Shared definitions for the L2 side of the L1<->L2 arbiter: responder FSM
// encoding and the request-field widths the arbiter also uses.
package l2_port_pkg;

  localparam int NUM_L1S      = 2;
  localparam int NUM_L1S_LOG  = 1;
  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 256;
  localparam int CPU_ID_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } l2_state_e;

endpackage

// File: rtl/l2_request_responder_if.sv
// Request, cache-array and response signals of the L2 responder.
// Handshakes: req_accept pops the arbiter FIFO on the edge where it is high;
// cache_req is held until cache_ready; cache_rdata is valid with cache_done;
// resp_valid is a one-cycle strobe, never raised while the target FIFO is full.
interface l2_request_responder_if #(
  parameter int num_L1s      = 2,
  parameter int num_L1s_log  = 1,
  parameter int addr_width   = 32,
  parameter int data_width   = 256,
  parameter int cpu_id_width = 2
);
  logic                    req_valid;
  logic                    req_rw;
  logic [addr_width-1:0]   req_addr;
  logic [data_width-1:0]   req_data;
  logic [cpu_id_width-1:0] req_id;
  logic [num_L1s_log-1:0]  req_src;
  logic                    req_accept;

  logic                    cache_req;
  logic                    cache_rw;
  logic [addr_width-1:0]   cache_addr;
  logic [data_width-1:0]   cache_wdata;
  logic                    cache_ready;
  logic                    cache_done;
  logic [data_width-1:0]   cache_rdata;

  logic [num_L1s-1:0]      resp_full;
  logic                    resp_valid;
  logic                    resp_rw;
  logic [addr_width-1:0]   resp_addr;
  logic [data_width-1:0]   resp_data;
  logic [cpu_id_width-1:0] resp_id;
  logic [num_L1s_log-1:0]  resp_dst;
  logic                    timeout_err;

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, req_id, req_src,
    output req_accept,
    output cache_req, cache_rw, cache_addr, cache_wdata,
    input  cache_ready, cache_done, cache_rdata,
    input  resp_full,
    output resp_valid, resp_rw, resp_addr, resp_data, resp_id, resp_dst,
    output timeout_err
  );

  modport master (
    output req_valid, req_rw, req_addr, req_data, req_id, req_src,
    input  req_accept,
    input  cache_req, cache_rw, cache_addr, cache_wdata,
    output cache_ready, cache_done, cache_rdata,
    output resp_full,
    input  resp_valid, resp_rw, resp_addr, resp_data, resp_id, resp_dst,
    input  timeout_err
  );
endinterface

// File: rtl/l2_port_watchdog.sv
// Wait-cycle counter for the responder; expired is high once the count has
// reached its all-ones limit, where it then holds.
module l2_port_watchdog #(
  parameter int width = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  logic [width-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = &count;

endmodule

// File: rtl/l2_request_responder.sv
// L2-side endpoint: pops one arbiter request, runs it through the L2 array
// and returns the tagged completion to the originating L1.
module l2_request_responder
  import l2_port_pkg::*;
#(
  parameter int num_L1s      = NUM_L1S,
  parameter int num_L1s_log  = NUM_L1S_LOG,
  parameter int addr_width   = ADDR_WIDTH,
  parameter int data_width   = DATA_WIDTH,
  parameter int cpu_id_width = CPU_ID_WIDTH,
  parameter int timeout_log  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  l2_request_responder_if.slave bus,
  output l2_state_e             dbg_state
);
  l2_state_e               state;
  logic                    rw_q;
  logic [addr_width-1:0]   addr_q;
  logic [data_width-1:0]   wdata_q;
  logic [cpu_id_width-1:0] id_q;
  logic [num_L1s_log-1:0]  src_q;
  logic [data_width-1:0]   data_q;
  logic                    timeout_q;

  logic                    dst_full;
  logic                    wd_clear;
  logic                    wd_inc;
  logic                    wd_expired;
  logic [data_width-1:0]   done_data;

  // Indices past num_L1s have no FIFO behind them, so they never block.
  always_comb begin
    dst_full = 1'b0;
    for (int i = 0; i < num_L1s; i++) begin
      if (int'(src_q) == i) dst_full = bus.resp_full[i];
    end
  end

  assign done_data = rw_q ? wdata_q : bus.cache_rdata;
  assign wd_clear  = enable && (state == ISSUE) && bus.cache_ready;
  assign wd_inc    = enable && (state == WAIT) && !bus.cache_done;

  // Timeout fires in the WAIT cycle whose count is already at the limit.
  l2_port_watchdog #(.width(timeout_log)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      id_q      <= '0;
      src_q     <= '0;
      data_q    <= '0;
      timeout_q <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            rw_q    <= bus.req_rw;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_data;
            id_q    <= bus.req_id;
            src_q   <= bus.req_src;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.cache_ready) begin
            if (bus.cache_done) begin
              data_q <= done_data;
              state  <= RESP;
            end else begin
              state  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.cache_done) begin
            data_q <= done_data;
            state  <= RESP;
          end else if (wd_expired) begin
            timeout_q <= 1'b1;
            data_q    <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (!dst_full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates the accept so an asserted reset never pops the arbiter.
  assign bus.req_accept  = enable && !reset && bus.req_valid && (state == IDLE);
  assign bus.cache_req   = enable && (state == ISSUE);
  assign bus.cache_rw    = rw_q;
  assign bus.cache_addr  = addr_q;
  assign bus.cache_wdata = wdata_q;

  assign bus.resp_valid  = enable && (state == RESP) && !dst_full;
  assign bus.resp_rw     = rw_q;
  assign bus.resp_addr   = addr_q;
  assign bus.resp_data   = data_q;
  assign bus.resp_id     = id_q;
  assign bus.resp_dst    = src_q;
  assign bus.timeout_err = timeout_q;

  assign dbg_state = state;

endmodule
